// File: rtl/writeback_queue.sv
// Writeback queue: merges load and ALU results into a circular buffer, retires one
// entry per cycle to registered register-file write ports, and forwards pending data.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              stall,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] fwd_reg,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [ADDR_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail_alu;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              full_ish, acc_mem, acc_alu, deq;

  // Stall leaves room for two entries so a dual request can always land whole.
  assign full_ish = (count_q >= CNT_W'(DEPTH - 1));
  assign stall    = !rst && full_ish;
  assign acc_mem  = mem_valid && !full_ish && (mem_reg != '0);
  assign acc_alu  = alu_valid && !full_ish && (alu_reg != '0);
  assign deq      = (count_q != '0);
  assign tail_alu = tail_q + PTR_W'(acc_mem);

  assign RegWrite  = regwrite_q;
  assign WriteReg  = writereg_q;
  assign WriteData = writedata_q;
  assign count     = ADDR_W'(count_q);

  // Next-state for pointers, occupancy and the retire registers.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q + PTR_W'(acc_mem) + PTR_W'(acc_alu);
    count_d     = count_q + CNT_W'(acc_mem) + CNT_W'(acc_alu) - CNT_W'(deq);
    regwrite_d  = deq;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (deq) begin
      head_d      = head_q + PTR_W'(1);
      writereg_d  = reg_q[head_q];
      writedata_d = data_q[head_q];
    end else begin
      head_d      = head_q;
    end
  end

  // Control state register; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
    end
  end

  // Entry storage; validity is tracked by head/count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (acc_mem) begin
      reg_q[tail_q]  <= mem_reg;
      data_q[tail_q] <= mem_data;
    end
    if (acc_alu) begin
      reg_q[tail_alu]  <= alu_reg;
      data_q[tail_alu] <= alu_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!rst && (fwd_reg != '0)) begin
      if (regwrite_q && (writereg_q == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = writedata_q;
      end else begin
        fwd_hit  = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < count_q) && (reg_q[head_q + PTR_W'(i)] == fwd_reg)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[head_q + PTR_W'(i)];
        end
      end
    end else begin
      fwd_hit  = 1'b0;
    end
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queued writeback entries (power of two, >= 2).
REQ-002 Parameter DATA_W, 8, register data width.
REQ-003 Parameter ADDR_W, 3, register index width (8 registers).
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_valid  input  1  load-result writeback request.
REQ-007 mem_reg  input  ADDR_W  destination register of load result.
REQ-008 mem_data  input  DATA_W  load result data.
REQ-009 alu_valid  input  1  ALU-result writeback request.
REQ-010 alu_reg  input  ADDR_W  destination register of ALU result.
REQ-011 alu_data  input  DATA_W  ALU result data.
REQ-012 stall  output  1  producers SHALL hold requests while high.
REQ-013 RegWrite  output  1  register-file write enable, registered.
REQ-014 WriteReg  output  ADDR_W  register-file write index, registered.
REQ-015 WriteData  output  DATA_W  register-file write data, registered.
REQ-016 fwd_reg  input  ADDR_W  register index being read by decode.
REQ-017 fwd_hit  output  1  a pending write to fwd_reg exists (combinational).
REQ-018 fwd_data  output  DATA_W  youngest pending data for fwd_reg (combinational).
REQ-019 count  output  ADDR_W  number of queued entries, 0..DEPTH.

Function
REQ-020 Circular buffer: head/tail pointers wrap modulo DEPTH; count tracks occupancy.
REQ-021 stall SHALL be 1 when count >= DEPTH-1 (room for fewer than two entries), else 0.
REQ-022 Requests presented while stall=1 SHALL be ignored (not enqueued).
REQ-023 A request with reg index 0 SHALL be discarded at enqueue ($0 is never written).
REQ-024 Both valid in the same cycle: mem entry enqueued first (older instruction), alu entry second.
REQ-025 Dequeue: each cycle with count > 0, head entry moves to the output registers; RegWrite=1 next cycle with that entry's WriteReg/WriteData.
REQ-026 Cycle with count = 0: RegWrite=0 next cycle; WriteReg/WriteData hold last values.
REQ-027 Latency: request accepted in cycle N into an empty queue -> RegWrite=1 in cycle N+2, one entry retired per cycle thereafter.
REQ-028 Simultaneous enqueue and dequeue: count(next) = count + accepted - dequeued; a just-enqueued entry is never dequeued in the same cycle.
REQ-029 Forwarding search covers all queued entries plus the output register while RegWrite=1.
REQ-030 Multiple matches: fwd_data SHALL take the youngest (queue tail side over head side over output register).
REQ-031 fwd_reg = 0 or no match: fwd_hit=0, fwd_data=0.
REQ-032 Queue never overflows; count never exceeds DEPTH.

Reset
REQ-033 rst=1 at a rising edge: count=0, head=tail=0, RegWrite=0, WriteReg=0, WriteData=0.
REQ-034 Reset SHALL override any same-cycle enqueue/dequeue; queued entries are lost.
REQ-035 During and after reset: stall=0, fwd_hit=0, fwd_data=0.

Verification
REQ-036 Single write: mem_valid, mem_reg=2, mem_data=13 in cycle 1 -> cycle 3 RegWrite=1, WriteReg=2, WriteData=13; cycle 4 RegWrite=0.
REQ-037 Ordering: same cycle mem(4,43) + alu(4,3) -> WriteReg=4 retires 43 then 3 on consecutive cycles; fwd_reg=4 returns 3 while both pending.
REQ-038 Zero register: alu_valid, alu_reg=0, alu_data=99 -> no RegWrite, count stays 0, fwd_reg=0 gives fwd_hit=0.
REQ-039 Fill/stall (DEPTH=4): both sources valid every cycle, regs 1..7 -> stall=1 once count>=3; all accepted entries retire in order, none lost, none duplicated, count never > 4.
REQ-040 Wrap-around: 10 successive single writes reg=5, data=1..10 -> RegWrite sequence 1..10 exactly, pointers wrap twice.
REQ-041 Reset mid-operation: 3 entries queued, rst=1 for one cycle -> next cycle count=0, RegWrite=0, fwd_hit=0; no queued write ever appears.
